// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : Stereo 16-bit Philips I2S transmitter with a pair FIFO,
//                integer SCLK divider and sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int SCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [15:0]                   left_in,
    input  logic [15:0]                   right_in,
    input  logic                          clear_flags,
    output logic                          i2s_sclk,
    output logic                          i2s_lrck,
    output logic                          i2s_dat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int               c_AW      = $clog2(FIFO_DEPTH);
    localparam int               c_DW      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [c_DW-1:0]  c_DIV_TC  = c_DW'(SCLK_DIV - 1);
    localparam logic [c_DW-1:0]  c_DIV_ONE = c_DW'(1);
    localparam logic [c_AW:0]    c_PTR_ONE = (c_AW + 1)'(1);

    logic [c_DW-1:0] r_div_cnt;
    logic            r_sclk;
    logic [5:0]      r_bit_cnt;
    logic            r_lrck;
    logic            r_dat;
    logic [c_AW:0]   r_wptr;
    logic [c_AW:0]   r_rptr;
    logic [c_AW:0]   r_level;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [15:0]     r_left_hold;
    logic [15:0]     r_right_hold;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_div_tc;
    logic            w_fall;
    logic [5:0]      w_bit_nxt;
    logic [4:0]      w_slot;
    logic [3:0]      w_idx;
    logic            w_in_data;
    logic [15:0]     w_cur_sample;
    logic            w_frame;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_underrun;
    logic [c_AW:0]   w_wptr_nxt;
    logic [c_AW:0]   w_rptr_nxt;
    logic [31:0]     w_rd_data;

    assign w_div_tc     = (r_div_cnt == c_DIV_TC);
    assign w_fall       = w_div_tc && r_sclk;
    assign w_bit_nxt    = r_bit_cnt + 6'd1;
    assign w_slot       = w_bit_nxt[4:0];
    // 16 - s for s in 1..16, computed modulo 16
    assign w_idx        = ~w_slot[3:0] + 4'd1;
    assign w_in_data    = (w_slot != 5'd0) && (w_slot <= 5'd16);
    assign w_cur_sample = w_bit_nxt[5] ? r_right_hold : r_left_hold;
    assign w_frame      = w_fall && (w_bit_nxt == 6'd0);

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                        (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    // Pop decisions use pre-cycle contents, so an empty FIFO never bypasses
    assign w_pop      = w_frame && !w_empty;
    assign w_push     = sample_valid && (!w_full || w_pop);
    assign w_drop     = sample_valid && !w_push;
    assign w_underrun = w_frame && w_empty;
    assign w_wptr_nxt = w_push ? r_wptr + c_PTR_ONE : r_wptr;
    assign w_rptr_nxt = w_pop  ? r_rptr + c_PTR_ONE : r_rptr;
    assign w_rd_data  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= {left_in, right_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_bit_cnt    <= 6'd63;
            r_lrck       <= 1'b0;
            r_dat        <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_div_tc) begin
                r_div_cnt <= '0;
                r_sclk    <= ~r_sclk;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end

            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= w_bit_nxt[5];
                r_dat     <= w_in_data ? w_cur_sample[w_idx] : 1'b0;
            end

            if (w_pop) begin
                r_left_hold  <= w_rd_data[31:16];
                r_right_hold <= w_rd_data[15:0];
            end

            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_wptr_nxt - w_rptr_nxt;

            // A set event in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end

            if (w_underrun) begin
                r_underflow <= 1'b1;
            end else if (clear_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign i2s_sclk   = r_sclk;
    assign i2s_lrck   = r_lrck;
    assign i2s_dat    = r_dat;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Scoreboard bench for audio_i2s_tx with a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam int D     = 2;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic          sample_valid = 1'b0;
    logic          clear_flags  = 1'b0;
    logic [15:0]   left_in      = '0;
    logic [15:0]   right_in     = '0;
    logic          i2s_sclk;
    logic          i2s_lrck;
    logic          i2s_dat;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          underflow;

    int tests = 0;
    int fails = 0;

    audio_i2s_tx #(.SCLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .left_in      (left_in),
        .right_in     (right_in),
        .clear_flags  (clear_flags),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_dat      (i2s_dat),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: frames load every 128*D cycles, first one 2*D cycles after release
    logic [31:0] mq[$];
    logic [31:0] exp_frames[$];
    logic [31:0] held     = '0;
    bit          exp_ovf  = 1'b0;
    bit          exp_udf  = 1'b0;
    bit          in_reset = 1'b1;
    int          cyc      = 0;

    function automatic bit is_load(input int c);
        return (c >= 2*D) && (((c - 2*D) % (128*D)) == 0);
    endfunction

    initial forever begin
        bit set_o, set_u;
        @(posedge clk);
        in_reset = reset;
        if (reset) begin
            mq.delete();
            exp_frames.delete();
            held    = '0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            cyc     = 0;
        end else begin
            cyc++;
            set_o = 1'b0;
            set_u = 1'b0;
            if (is_load(cyc)) begin
                if (mq.size() > 0) held = mq.pop_front();
                else               set_u = 1'b1;
                exp_frames.push_back(held);
            end
            if (sample_valid) begin
                if (mq.size() < DEPTH) mq.push_back({left_in, right_in});
                else                   set_o = 1'b1;
            end
            if (clear_flags) begin
                exp_ovf = 1'b0;
                exp_udf = 1'b0;
            end
            if (set_o) exp_ovf = 1'b1;
            if (set_u) exp_udf = 1'b1;
        end
    end

    // Monitor: decodes the serial stream on SCLK rising edges and scores frames
    bit          prev_sclk = 1'b0;
    bit          have_frame = 1'b0;
    int          ridx = 0;
    int          mb, ms, bad_fmt;
    int          frames_checked = 0;
    logic [15:0] got_l, got_r;
    logic [31:0] exp_pair;

    initial forever begin
        @(negedge clk);
        if (in_reset) begin
            prev_sclk  = 1'b0;
            have_frame = 1'b0;
            ridx       = 0;
            tests++;
            if ({i2s_sclk, i2s_lrck, i2s_dat, overflow, underflow} !== 5'b0 || fifo_level !== '0) begin
                fails++;
                $display("FAIL reset_values: sclk=%b lrck=%b dat=%b level=%0d ovf=%b udf=%b, required all 0",
                         i2s_sclk, i2s_lrck, i2s_dat, fifo_level, overflow, underflow);
            end
        end else begin
            tests++;
            if (fifo_level !== LW'(mq.size()) || overflow !== exp_ovf || underflow !== exp_udf) begin
                fails++;
                $display("FAIL status @cyc %0d: level=%0d ovf=%b udf=%b, required level=%0d ovf=%b udf=%b",
                         cyc, fifo_level, overflow, underflow, mq.size(), exp_ovf, exp_udf);
            end
            if (i2s_sclk && !prev_sclk) begin
                mb = (ridx == 0) ? 63 : (ridx - 1) % 64;
                ridx++;
                if (mb == 0) begin
                    have_frame = 1'b1;
                    got_l      = '0;
                    got_r      = '0;
                    bad_fmt    = 0;
                end
                if (have_frame) begin
                    if (i2s_lrck !== (mb >= 32)) bad_fmt++;
                    ms = mb % 32;
                    if (ms >= 1 && ms <= 16) begin
                        if (mb < 32) got_l[16-ms] = i2s_dat;
                        else         got_r[16-ms] = i2s_dat;
                    end else if (i2s_dat !== 1'b0) begin
                        bad_fmt++;
                    end
                    if (mb == 63) begin
                        tests++;
                        if (exp_frames.size() == 0) begin
                            fails++;
                            $display("FAIL frame_missing: got %h_%h, required no frame", got_l, got_r);
                        end else begin
                            exp_pair = exp_frames.pop_front();
                            frames_checked++;
                            if ({got_l, got_r} !== exp_pair) begin
                                fails++;
                                $display("FAIL frame_data: got L=%h R=%h, required L=%h R=%h",
                                         got_l, got_r, exp_pair[31:16], exp_pair[15:0]);
                            end
                        end
                        tests++;
                        if (bad_fmt != 0) begin
                            fails++;
                            $display("FAIL frame_format: %0d bad lrck/padding bits, required 0", bad_fmt);
                        end
                    end
                end
            end
            prev_sclk = i2s_sclk;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        sample_valid = 1'b1;
        left_in      = l;
        right_in     = r;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
    endtask

    task automatic wait_before_load();
        int n = 0;
        while (!is_load(cyc + 1) && n < 200*D) begin
            tick();
            n++;
        end
        if (n >= 200*D) begin
            tests++;
            fails++;
            $display("FAIL wait_load_timeout: waited %0d cycles, required < %0d", n, 200*D);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * 128 * D) tick();
    endtask

    initial begin
        int n;
        // reset held for 3 cycles
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // serialization then underflow repeat
        push(16'hA5C3, 16'h3C5A);
        wait_frames(3);
        pulse_clear();
        tick();

        // overflow: 5 back-to-back pushes into an empty FIFO just after a load
        wait_before_load();
        tick();
        for (int i = 1; i <= 5; i++) push(16'(i), 16'(i + 16'h100));
        wait_frames(6);

        // full FIFO with push landing on the frame-load pop
        pulse_clear();
        wait_before_load();
        tick();
        for (int i = 0; i < 4; i++) push(16'h1100 + 16'(i), 16'h2200 + 16'(i));
        wait_before_load();
        sample_valid = 1'b1;
        left_in      = 16'h7777;
        right_in     = 16'h8888;
        tick();
        sample_valid = 1'b0;
        tick();
        tests++;
        if (fifo_level !== LW'(4)) begin
            fails++;
            $display("FAIL full_pop_level: got %0d, required 4", fifo_level);
        end
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_overflow: got %b, required 0", overflow);
        end
        wait_frames(6);

        // randomized traffic, sparse then dense
        for (int i = 0; i < 12 * 128 * D; i++) begin
            sample_valid = ($urandom_range(0, (i < 6*128*D) ? 300 : 50) == 0);
            left_in      = 16'($urandom);
            right_in     = 16'($urandom);
            clear_flags  = ($urandom_range(0, 499) == 0);
            tick();
        end
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        wait_frames(6);

        // reset at b=20 with 3 entries queued
        wait_before_load();
        tick();
        for (int i = 0; i < 3; i++) push(16'($urandom), 16'($urandom));
        n = 0;
        while (!(cyc >= 2*D && (cyc % (2*D)) == 0 && ((cyc / (2*D) - 1) % 64) == 20) && n < 300*D) begin
            tick();
            n++;
        end
        if (n >= 300*D) begin
            tests++;
            fails++;
            $display("FAIL wait_b20_timeout: waited %0d cycles, required < %0d", n, 300*D);
        end
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        wait_frames(3);

        tests++;
        if (frames_checked < 20) begin
            fails++;
            $display("FAIL frames_seen: got %0d frames, required >= 20", frames_checked);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
